// File: rtl/spi_memory_burst.sv
// SPI-slave (mode 0, MSB first) register file with burst transfers and wrapping address.
// SPI pins are synchronised internally; all protocol logic runs in the clk domain.
module spi_memory_burst #(
   parameter int DATA_W      = 8,
   parameter int ADDR_W      = 7,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sclk_pin,
   input  logic              cs_pin,
   input  logic              mosi_pin,
   output logic              miso_pin,
   output logic              miso_oe,
   output logic              busy,
   output logic              wr_pulse,
   output logic [ADDR_W-1:0] addr_cur
);

   localparam int IN_W  = (ADDR_W + 1 > DATA_W) ? ADDR_W + 1 : DATA_W;
   localparam int SH_W  = IN_W - 1;
   localparam int CNT_W = $clog2(IN_W + 1);
   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD,
      S_READ_LOAD,
      S_READ,
      S_WRITE
   } state_t;

   state_t state, state_nxt;

   logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
   logic                   sclk_d, cs_d;
   logic                   sclk_s, cs_s, mosi_s;
   logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

   logic [SH_W-1:0]   in_sr;
   logic [DATA_W-1:0] out_sr;
   logic [CNT_W-1:0]  bit_cnt;
   logic [DATA_W-1:0] mem [DEPTH];

   logic              sh_rise, sh_fall, cmd_done, word_done, mem_we;
   logic [DATA_W-1:0] wdata;
   logic [ADDR_W-1:0] addr_inc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sync <= '0;
         cs_sync   <= '1;
         mosi_sync <= '0;
         sclk_d    <= 1'b0;
         cs_d      <= 1'b1;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_pin};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_pin};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_pin};
         sclk_d    <= sclk_sync[SYNC_STAGES-1];
         cs_d      <= cs_sync[SYNC_STAGES-1];
      end
   end

   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign cs_s      = cs_sync[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_d;
   assign sclk_fall = ~sclk_s & sclk_d;
   assign cs_rise   = cs_s & ~cs_d;
   assign cs_fall   = ~cs_s & cs_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // cs rise overrides any sclk edge detected in the same cycle.
   always_comb begin
      state_nxt = state;
      sh_rise   = 1'b0;
      sh_fall   = 1'b0;
      cmd_done  = 1'b0;
      word_done = 1'b0;
      if (cs_rise) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE: if (cs_fall) state_nxt = S_CMD;
            S_CMD: begin
               if (sclk_rise) begin
                  sh_rise = 1'b1;
                  if (bit_cnt == CNT_W'(ADDR_W)) begin
                     cmd_done  = 1'b1;
                     state_nxt = mosi_s ? S_READ_LOAD : S_WRITE;
                  end
               end
            end
            S_READ_LOAD: state_nxt = S_READ;
            S_READ, S_WRITE: begin
               sh_fall = sclk_fall;
               if (sclk_rise) begin
                  sh_rise   = 1'b1;
                  word_done = (bit_cnt == CNT_W'(DATA_W - 1));
               end
            end
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   assign mem_we   = (state == S_WRITE) && word_done;
   assign wdata    = {in_sr[DATA_W-2:0], mosi_s};
   assign addr_inc = addr_cur + ADDR_W'(1);
   assign busy     = (state != S_IDLE);
   assign miso_oe  = (state == S_READ_LOAD) || (state == S_READ);

   // Memory has no reset so its contents survive rst_n.
   always_ff @(posedge clk) begin
      if (mem_we) mem[addr_cur] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_sr    <= '0;
         out_sr   <= '0;
         bit_cnt  <= '0;
         miso_pin <= 1'b0;
         wr_pulse <= 1'b0;
         addr_cur <= '0;
      end else begin
         wr_pulse <= mem_we;
         if (cs_rise || (state == S_IDLE)) begin
            bit_cnt <= '0;
         end else if (sh_rise) begin
            in_sr   <= SH_W'({in_sr, mosi_s});
            bit_cnt <= (cmd_done || word_done) ? '0 : bit_cnt + CNT_W'(1);
         end
         if (cmd_done) addr_cur <= in_sr[ADDR_W-1:0];
         if (word_done) addr_cur <= addr_inc;
         if ((state == S_READ_LOAD) && !cs_rise) out_sr <= mem[addr_cur];
         // The next word is loaded on the last sampling edge so the burst has no gap bit.
         if ((state == S_READ) && word_done) out_sr <= mem[addr_inc];
         if (sh_fall && (state == S_READ)) begin
            miso_pin <= out_sr[DATA_W-1];
            out_sr   <= out_sr << 1;
         end
      end
   end

endmodule

// File: tb/tb_spi_memory_burst.sv
// Bench for spi_memory_burst: an SPI-master driver plus pin-level monitors that
// compare observed read words and write strobes against expected queues.
module tb_spi_memory_burst;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 7;
   localparam int HALF   = 8;

   logic              clk;
   logic              rst_n;
   logic              sclk_pin;
   logic              cs_pin;
   logic              mosi_pin;
   logic              miso_pin;
   logic              miso_oe;
   logic              busy;
   logic              wr_pulse;
   logic [ADDR_W-1:0] addr_cur;

   logic [DATA_W-1:0] exp_q[$];
   logic [ADDR_W-1:0] exp_wr_q[$];

   int n_pass  = 0;
   int n_total = 0;

   spi_memory_burst #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SYNC_STAGES(2)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .sclk_pin (sclk_pin),
      .cs_pin   (cs_pin),
      .mosi_pin (mosi_pin),
      .miso_pin (miso_pin),
      .miso_oe  (miso_oe),
      .busy     (busy),
      .wr_pulse (wr_pulse),
      .addr_cur (addr_cur)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic spi_start();
      cs_pin = 1'b0;
      wait_clks(HALF);
   endtask

   task automatic spi_bits(input logic [7:0] v, input int nbits);
      for (int i = 7; i > 7 - nbits; i--) begin
         mosi_pin = v[i];
         wait_clks(HALF);
         sclk_pin = 1'b1;
         wait_clks(HALF);
         sclk_pin = 1'b0;
      end
   endtask

   task automatic spi_end();
      wait_clks(HALF);
      cs_pin = 1'b1;
      wait_clks(HALF + 4);
   endtask

   // Read monitor: decodes the command from the pins and collects data words.
   int                mon_bit = 0;
   logic              rd_mode = 1'b0;
   logic [DATA_W-1:0] mon_acc = '0;

   always @(negedge cs_pin) mon_bit = 0;

   always @(posedge sclk_pin) begin
      if (!cs_pin && rst_n) begin
         if (mon_bit == ADDR_W) begin
            rd_mode = mosi_pin;
         end else if (mon_bit > ADDR_W) begin
            mon_acc = {mon_acc[DATA_W-2:0], miso_pin};
            if ((mon_bit - ADDR_W - 1) % DATA_W == DATA_W - 1) begin
               if (rd_mode) begin
                  if (exp_q.size() == 0) check("rd_unexpected", 1, 0);
                  else check("rd_word", mon_acc, exp_q.pop_front());
                  check("oe_read", miso_oe, 1);
               end else begin
                  check("oe_write", miso_oe, 0);
               end
            end
         end
         mon_bit++;
      end
   end

   always @(negedge clk) begin
      if (wr_pulse) begin
         if (exp_wr_q.size() == 0) check("wr_unexpected", 1, 0);
         else check("wr_addr", addr_cur, exp_wr_q.pop_front());
      end
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      rst_n    = 1'b0;
      sclk_pin = 1'b0;
      cs_pin   = 1'b1;
      mosi_pin = 1'b0;
      wait_clks(4);
      check("rst_busy", busy, 0);
      check("rst_miso_oe", miso_oe, 0);
      check("rst_miso", miso_pin, 0);
      check("rst_wr_pulse", wr_pulse, 0);
      check("rst_addr", addr_cur, 0);
      rst_n = 1'b1;
      wait_clks(4);

      // Single write of 0x5A to 0x12
      exp_wr_q.push_back(7'h13);
      spi_start();
      spi_bits(8'h24, 8);
      spi_bits(8'h5A, 8);
      spi_end();
      check("t1_addr", addr_cur, 7'h13);
      check("t1_busy", busy, 0);

      // Readback of 0x12
      exp_q.push_back(8'h5A);
      spi_start();
      spi_bits(8'h25, 8);
      spi_bits(8'h00, 8);
      spi_end();
      check("t2_oe_after", miso_oe, 0);

      // Write burst wrapping 0x7F -> 0x00
      exp_wr_q.push_back(7'h00);
      exp_wr_q.push_back(7'h01);
      spi_start();
      spi_bits(8'hFE, 8);
      spi_bits(8'hA1, 8);
      spi_bits(8'hB2, 8);
      spi_end();
      check("t3_addr", addr_cur, 7'h01);

      // Read burst wrapping
      exp_q.push_back(8'hA1);
      exp_q.push_back(8'hB2);
      spi_start();
      spi_bits(8'hFF, 8);
      spi_bits(8'h00, 8);
      spi_bits(8'h00, 8);
      spi_end();

      // Three-word burst at 0x40 with extreme patterns, then read back
      exp_wr_q.push_back(7'h41);
      exp_wr_q.push_back(7'h42);
      exp_wr_q.push_back(7'h43);
      spi_start();
      spi_bits(8'h80, 8);
      spi_bits(8'h00, 8);
      spi_bits(8'hFF, 8);
      spi_bits(8'h3C, 8);
      spi_end();
      exp_q.push_back(8'h00);
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'h3C);
      spi_start();
      spi_bits(8'h81, 8);
      for (int i = 0; i < 3; i++) spi_bits(8'h00, 8);
      spi_end();

      // Abort: partial word must not be written
      spi_start();
      spi_bits(8'h24, 8);
      spi_bits(8'hFF, 5);
      spi_end();
      check("t5_busy", busy, 0);
      exp_q.push_back(8'h5A);
      spi_start();
      spi_bits(8'h25, 8);
      spi_bits(8'h00, 8);
      spi_end();

      // Reset mid-read
      spi_start();
      spi_bits(8'h25, 8);
      spi_bits(8'h00, 3);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("t6_busy", busy, 0);
      check("t6_miso_oe", miso_oe, 0);
      check("t6_miso", miso_pin, 0);
      check("t6_wr_pulse", wr_pulse, 0);
      check("t6_addr", addr_cur, 0);
      cs_pin = 1'b1;
      wait_clks(4);
      rst_n = 1'b1;
      wait_clks(8);
      exp_q.push_back(8'h5A);
      spi_start();
      spi_bits(8'h25, 8);
      spi_bits(8'h00, 8);
      spi_end();

      wait_clks(10);
      check("rd_queue_empty", exp_q.size(), 0);
      check("wr_queue_empty", exp_wr_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
